// File: rtl/rf_writeback_if.sv
// Interface for the register-file writeback stage.
// It carries the ALU result bus, the load offer/ready handshake, the PC step
// request, and the registered register-file outputs.
//   master : the upstream pipeline or bench. It drives alu_*, ld_valid/addr/data
//            and pc_advance, and observes the RF_* outputs and status.
//   slave  : rf_writeback itself.
interface rf_writeback_if #(
   parameter int unsigned ADDRLEN  = 4,
   parameter int unsigned DBUSLEN  = 32,
   parameter int unsigned FLAGSLEN = 32
);
   logic                alu_valid;
   logic                alu_wen;
   logic [ADDRLEN-1:0]  alu_addr;
   logic [DBUSLEN-1:0]  alu_data;
   logic                alu_fen;
   logic [FLAGSLEN-1:0] alu_flags;
   logic                ld_valid;
   logic                ld_ready;
   logic [ADDRLEN-1:0]  ld_addr;
   logic [DBUSLEN-1:0]  ld_data;
   logic                pc_advance;
   logic [ADDRLEN-1:0]  RF_Addr_Write;
   logic [DBUSLEN-1:0]  RF_Bus_Write;
   logic                RF_Load_Write;
   logic [FLAGSLEN-1:0] RF_Flags_Write;
   logic                RF_Load_Flags;
   logic [DBUSLEN-1:0]  RF_PC_Write;
   logic                wb_busy;
   logic                flush;

   modport master (
      output alu_valid, alu_wen, alu_addr, alu_data, alu_fen, alu_flags,
      output ld_valid, ld_addr, ld_data, pc_advance,
      input  ld_ready, RF_Addr_Write, RF_Bus_Write, RF_Load_Write,
      input  RF_Flags_Write, RF_Load_Flags, RF_PC_Write, wb_busy, flush
   );

   modport slave (
      input  alu_valid, alu_wen, alu_addr, alu_data, alu_fen, alu_flags,
      input  ld_valid, ld_addr, ld_data, pc_advance,
      output ld_ready, RF_Addr_Write, RF_Bus_Write, RF_Load_Write,
      output RF_Flags_Write, RF_Load_Flags, RF_PC_Write, wb_busy, flush
   );
endinterface

// File: rtl/rf_writeback.sv
// Register-file writeback stage.
// The stage chooses at most one register write per cycle. An ALU write has
// priority. Otherwise the head of a 2-entry load buffer is written. A flags
// update travels on its own port. A write to r15 redirects the PC and
// raises flush for one cycle. All RF_* outputs are registered, so they
// appear one cycle after the selection.
// Ports:
//   sysclk : clock, rising edge.
//   nreset : asynchronous active-low reset.
//   bus    : rf_writeback_if.slave. It carries the ALU inputs, the load
//            handshake, pc_advance, the RF_* outputs, wb_busy and flush.
module rf_writeback #(
   parameter int unsigned        ADDRLEN  = 4,
   parameter int unsigned        DBUSLEN  = 32,
   parameter int unsigned        FLAGSLEN = 32,
   parameter logic [DBUSLEN-1:0] RESET_PC = '0
) (
   input logic           sysclk,
   input logic           nreset,
   rf_writeback_if.slave bus
);

   localparam logic [ADDRLEN-1:0] PcAddr = ADDRLEN'(15);

   typedef enum logic [1:0] {CntEmpty, CntOne, CntFull} cnt_e;

   cnt_e                          cnt_q, cnt_d;
   logic [1:0][ADDRLEN-1:0]       ent_addr_q, ent_addr_d;
   logic [1:0][DBUSLEN-1:0]       ent_data_q, ent_data_d;

   logic                          load_write_q;
   logic [ADDRLEN-1:0]            addr_write_q;
   logic [DBUSLEN-1:0]            bus_write_q;
   logic                          load_flags_q;
   logic [FLAGSLEN-1:0]           flags_write_q;
   logic                          flush_q;
   logic [DBUSLEN-1:0]            pc_q;

   logic                          alu_wr, alu_flag;
   logic                          occ0, occ1, keep0, keep1;
   logic                          ld_ready, push;
   logic                          wr_valid, redirect;
   logic [ADDRLEN-1:0]            wr_addr;
   logic [DBUSLEN-1:0]            wr_data;
   logic [1:0]                    n_keep, n_total;

   // Write selection, pop and squash.
   always_comb begin
      alu_wr   = bus.alu_valid & bus.alu_wen;
      alu_flag = bus.alu_valid & bus.alu_fen;
      occ0     = (cnt_q != CntEmpty);
      occ1     = (cnt_q == CntFull);
      // ld_ready reflects the occupancy at the edge, so a full buffer never
      // takes a load even when a slot frees up in the same cycle.
      ld_ready = (cnt_q != CntFull);
      push     = bus.ld_valid & ld_ready;
      keep0    = occ0;
      keep1    = occ1;
      wr_valid = 1'b0;
      wr_addr  = ent_addr_q[0];
      wr_data  = ent_data_q[0];
      if (alu_wr) begin
         wr_valid = 1'b1;
         wr_addr  = bus.alu_addr;
         wr_data  = bus.alu_data;
         // A queued load to the same register is older than the ALU result.
         // Drop it so that it cannot overwrite the newer value later.
         if (ent_addr_q[0] == bus.alu_addr) keep0 = 1'b0;
         if (ent_addr_q[1] == bus.alu_addr) keep1 = 1'b0;
      end else if (occ0) begin
         wr_valid = 1'b1;
         keep0    = 1'b0;
      end
      redirect = wr_valid & (wr_addr == PcAddr);
   end

   // Buffer next state: compact the surviving entries, then append the push.
   always_comb begin
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      n_keep     = 2'd0;
      case ({keep1, keep0})
         2'b00: n_keep = 2'd0;
         2'b01: n_keep = 2'd1;
         2'b10: begin
            ent_addr_d[0] = ent_addr_q[1];
            ent_data_d[0] = ent_data_q[1];
            n_keep        = 2'd1;
         end
         2'b11: n_keep = 2'd2;
         default: n_keep = 2'd0;
      endcase
      n_total = n_keep;
      if (push) begin
         ent_addr_d[n_keep[0]] = bus.ld_addr;
         ent_data_d[n_keep[0]] = bus.ld_data;
         n_total               = n_keep + 2'd1;
      end
      case (n_total)
         2'd0:    cnt_d = CntEmpty;
         2'd1:    cnt_d = CntOne;
         default: cnt_d = CntFull;
      endcase
   end

   always_ff @(posedge sysclk or negedge nreset) begin
      if (!nreset) begin
         cnt_q         <= CntEmpty;
         ent_addr_q    <= '0;
         ent_data_q    <= '0;
         load_write_q  <= 1'b0;
         addr_write_q  <= '0;
         bus_write_q   <= '0;
         load_flags_q  <= 1'b0;
         flags_write_q <= '0;
         flush_q       <= 1'b0;
         pc_q          <= RESET_PC;
      end else begin
         cnt_q        <= cnt_d;
         ent_addr_q   <= ent_addr_d;
         ent_data_q   <= ent_data_d;
         // A write to r15 goes to the PC, not to the register file.
         load_write_q <= wr_valid & ~redirect;
         if (wr_valid & ~redirect) begin
            addr_write_q <= wr_addr;
            bus_write_q  <= wr_data;
         end
         load_flags_q <= alu_flag;
         if (alu_flag) flags_write_q <= bus.alu_flags;
         flush_q <= redirect;
         if (redirect) begin
            pc_q <= {wr_data[DBUSLEN-1:2], 2'b00};
         end else if (bus.pc_advance) begin
            pc_q <= pc_q + DBUSLEN'(4);
         end
      end
   end

   assign bus.ld_ready       = ld_ready;
   assign bus.wb_busy        = (cnt_q != CntEmpty);
   assign bus.RF_Load_Write  = load_write_q;
   assign bus.RF_Addr_Write  = addr_write_q;
   assign bus.RF_Bus_Write   = bus_write_q;
   assign bus.RF_Load_Flags  = load_flags_q;
   assign bus.RF_Flags_Write = flags_write_q;
   assign bus.flush          = flush_q;
   assign bus.RF_PC_Write    = pc_q;

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL provide parameter ADDRLEN, default 4: register-file write address width.
REQ-002 SHALL provide parameter DBUSLEN, default 32: data and PC width.
REQ-003 SHALL provide parameter FLAGSLEN, default 32: PSR/flags word width.
REQ-004 SHALL provide parameter RESET_PC, default 0: PC value after reset.
REQ-005 SHALL provide ports (one clock; reset asynchronous, active-low):
- sysclk  in  1  sole clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_wen  in  1  ALU result writes a register.
- alu_addr  in  ADDRLEN  ALU destination register.
- alu_data  in  DBUSLEN  ALU result.
- alu_fen  in  1  ALU result updates flags.
- alu_flags  in  FLAGSLEN  new flags word.
- ld_valid  in  1  load data offered.
- ld_ready  out  1  load buffer can accept.
- ld_addr  in  ADDRLEN  load destination register.
- ld_data  in  DBUSLEN  load data.
- pc_advance  in  1  sequential PC step request.
- RF_Addr_Write  out  ADDRLEN  register-file write address.
- RF_Bus_Write  out  DBUSLEN  register-file write data.
- RF_Load_Write  out  1  register-file write strobe.
- RF_Flags_Write  out  FLAGSLEN  flags write data.
- RF_Load_Flags  out  1  flags write strobe.
- RF_PC_Write  out  DBUSLEN  PC value presented to the register file.
- wb_busy  out  1  load buffer non-empty.
- flush  out  1  one-cycle pulse following a PC redirect.

Function
REQ-006 SHALL hold loads in a 2-entry FIFO (count states EMPTY/ONE/FULL); ld_ready = count != 2; push on ld_valid & ld_ready.
REQ-007 SHALL select one register write per cycle: ALU (alu_valid & alu_wen) has priority; otherwise the FIFO head pops and is written.
REQ-008 SHALL pop the FIFO in the same cycle as an ALU flags-only update (alu_fen, no alu_wen); the register and flags ports are independent.
REQ-009 SHALL register all RF_* outputs: a selection sampled at edge N drives RF_* from edge N until edge N+1 (1-cycle latency); strobes are 0 on idle cycles.
REQ-010 SHALL, when an ALU register write addresses a valid FIFO entry, squash that entry (removed with no write) because the ALU result is younger; the squash and any push occur in the same cycle.
REQ-011 SHALL allow a push into the slot freed by a same-cycle pop or squash only when ld_ready was high at that edge; there is no bypass of a full buffer.
REQ-012 SHALL treat a selected write to address 15 as a PC redirect: RF_Load_Write stays 0, pc <= data with bits[1:0] cleared, and flush = 1 for the following cycle.
REQ-013 SHALL otherwise set pc <= pc + 4 (modulo 2^DBUSLEN) when pc_advance = 1; a redirect overrides pc_advance in the same cycle.
REQ-014 SHALL drive RF_PC_Write = pc continuously.
REQ-015 SHALL drive RF_Load_Flags = 1 and RF_Flags_Write = alu_flags one cycle after alu_valid & alu_fen.
REQ-016 SHALL drive wb_busy = (count != 0).
REQ-017 SHALL ignore alu_wen, alu_fen and all alu_* data when alu_valid = 0.

Reset
REQ-018 SHALL, on nreset low (asynchronous, any cycle including mid-transfer), clear the FIFO and set ld_ready=1, wb_busy=0, flush=0, RF_Load_Write=0, RF_Load_Flags=0, RF_Addr_Write=0, RF_Bus_Write=0, RF_Flags_Write=0, and pc = RF_PC_Write = RESET_PC.
REQ-019 SHALL resume normal operation at the first rising sysclk edge after nreset deasserts.

Verification
REQ-020 SHALL cover: ALU write r0=0x000000FF -> next cycle RF_Load_Write=1, RF_Addr_Write=0, RF_Bus_Write=0xFF.
REQ-021 SHALL cover: loads r1=0xFFFF and r2=0x0FFF pushed while the ALU writes r3 for 2 cycles -> ld_ready=0 after the second push; r1 then r2 written in the next two idle cycles; wb_busy then falls.
REQ-022 SHALL cover: load r4=0x20 queued, then ALU writes r4=0x40 -> the load is squashed; only 0x40 is written to r4.
REQ-023 SHALL cover: pc_advance held for 3 cycles from reset -> RF_PC_Write reads 0, 4, 8, 12; ALU write r15=0x103 -> pc=0x100, flush pulses once, RF_Load_Write=0.
REQ-024 SHALL cover: pc=0xFFFFFFFC with pc_advance=1 -> wraps to 0x00000000.
REQ-025 SHALL cover: nreset asserted with 2 loads queued -> buffer empty, ld_ready=1, RF_PC_Write=RESET_PC immediately, and no write after release.
